demux4_reg: RTL
===============

DEMUX4_REG -- requirements
Module: demux4_reg

Interface
REQ-001 Parameter N, default 8, data width of the input and of every output channel.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 d  input  N  input data word.
REQ-005 d_valid  input  1  input word present this cycle.
REQ-006 d_ready  output  1  block accepts the input word this cycle.
REQ-007 s  input  2  destination select (00->ch0 .. 11->ch3); used when auto=0.
REQ-008 auto  input  1  1 = round-robin destination from internal pointer; 0 = destination from s.
REQ-009 y0..y3  output  N each  channel data, registered.
REQ-010 v0..v3  output  1 each  channel word valid.
REQ-011 r0..r3  input  1 each  downstream ready per channel.
REQ-012 rr_ptr  output  2  current round-robin pointer, registered.

Function
REQ-013 Destination dst SHALL be rr_ptr when auto=1, else s; evaluated combinationally each cycle.
REQ-014 Each channel k SHALL hold a one-entry buffer: yk data, vk full flag.
REQ-015 d_ready SHALL be (~v[dst]) | r[dst]; no dependence on d_valid (no combinational valid->ready path).
REQ-016 Accept = d_valid & d_ready; on accept, y[dst] <= d and v[dst] <= 1 at next edge; latency one cycle.
REQ-017 Output transfer on channel k = vk & rk; on transfer without simultaneous load into k, vk <= 0 next edge.
REQ-018 Simultaneous transfer out and load into same channel SHALL keep vk=1 and replace yk with new d (full throughput, one word/cycle per channel).
REQ-019 Channels not equal to dst SHALL be unaffected by input activity; yk SHALL hold while vk=1 and rk=0.
REQ-020 yk contents when vk=0 are don't-care for function but SHALL not change except on a load.
REQ-021 rr_ptr SHALL increment by 1 on every accept while auto=1, wrapping 3->0; no change when auto=0 or no accept.
REQ-022 A blocked round-robin destination SHALL stall input (d_ready=0); pointer SHALL NOT skip a full channel.
REQ-023 Changing s or auto while d_valid=1 and d_ready=0 is permitted; dst follows the new value immediately.

Reset
REQ-024 When rst=1 at a rising edge: v0..v3 <= 0, y0..y3 <= 0, rr_ptr <= 0; reset overrides any simultaneous accept or transfer.
REQ-025 d_ready during and after reset SHALL follow REQ-015 with all vk=0 (i.e. 1 after the reset edge).
REQ-026 Reset mid-operation SHALL discard all buffered words without output transfer.

Structure
REQ-027 Select encodings (CH0..CH3 = 2'b00..2'b11) and default width SHALL live in shared package demux_pkg.
REQ-028 The per-channel one-entry buffer SHALL be a sub-module demux_slot (inputs load, load_data, rdy; outputs y, v), instantiated four times.
REQ-029 Destination decode and round-robin pointer SHALL be in demux4_reg top level; fully synchronous, no latches.

Verification
REQ-030 Fixed select: auto=0, s=2, d=8'hA5, d_valid=1 one cycle, r2=0 -> next cycle y2=A5, v2=1, v0/v1/v3=0; y2 holds until r2=1, then v2=0 next cycle.
REQ-031 Back-pressure: v1=1, r1=0, s=1, d_valid=1 -> d_ready=0, y1 unchanged; raise r1 -> d_ready=1, y1 replaced by new d, v1 stays 1.
REQ-032 Round-robin: auto=1, all r=1, d_valid=1 for 6 cycles with d=1..6 -> loads go ch0,1,2,3,0,1; rr_ptr sequence 0,1,2,3,0,1,2 (wrap verified).
REQ-033 Round-robin stall: auto=1, rr_ptr=2, v2=1, r2=0 -> d_ready=0, rr_ptr stays 2 even if ch3 empty.
REQ-034 Reset mid-stream: v0..v3 all 1, assert rst with d_valid=1 -> next cycle all vk=0, yk=0, rr_ptr=0, d_ready=1.
REQ-035 Scoreboard: random d_valid/rk/s/auto for 10k cycles -> every accepted word appears exactly once, in order, on its destination channel.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared definitions for the registered 1-to-4 demultiplexer: select codes,
// default data width and the round-robin pointer step.
package demux_pkg;

    localparam int unsigned DEMUX_N_DEF  = 8;
    localparam int unsigned DEMUX_NCH    = 4;
    localparam int unsigned DEMUX_SEL_W  = 2;

    typedef enum logic [DEMUX_SEL_W-1:0] {
        CH0 = 2'b00,
        CH1 = 2'b01,
        CH2 = 2'b10,
        CH3 = 2'b11
    } demux_sel_e;

    // Next round-robin destination; wraps CH3 -> CH0.
    function automatic logic [DEMUX_SEL_W-1:0] rr_next(input logic [DEMUX_SEL_W-1:0] ptr);
        return DEMUX_SEL_W'(ptr + DEMUX_SEL_W'(1));
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output buffer for a single demux channel: load fills it, a
// downstream transfer (v & rdy) empties it unless a load lands in the same cycle.
module demux_slot #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N-1:0] load_data,
    input  logic         rdy,
    output logic [N-1:0] y,
    output logic         v
);

    logic [N-1:0] y_q, y_d;
    logic         v_q, v_d;

    // Load wins over drain so a full slot sustains one word per cycle.
    always_comb begin
        y_d = y_q;
        v_d = v_q;
        if (load) begin
            y_d = load_data;
            v_d = 1'b1;
        end else if (v_q && rdy) begin
            v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
            v_q <= 1'b0;
        end else begin
            y_q <= y_d;
            v_q <= v_d;
        end
    end

    assign y = y_q;
    assign v = v_q;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel one-entry buffers and
// either explicit (s) or round-robin destination selection.
module demux4_reg
    import demux_pkg::*;
#(
    parameter int unsigned N = DEMUX_N_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           d,
    input  logic                   d_valid,
    output logic                   d_ready,
    input  logic [DEMUX_SEL_W-1:0] s,
    input  logic                   auto,
    output logic [N-1:0]           y0,
    output logic [N-1:0]           y1,
    output logic [N-1:0]           y2,
    output logic [N-1:0]           y3,
    output logic                   v0,
    output logic                   v1,
    output logic                   v2,
    output logic                   v3,
    input  logic                   r0,
    input  logic                   r1,
    input  logic                   r2,
    input  logic                   r3,
    output logic [DEMUX_SEL_W-1:0] rr_ptr
);

    logic [DEMUX_SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    demux_sel_e             dst_c;
    logic [DEMUX_NCH-1:0]   r_c;
    logic [DEMUX_NCH-1:0]   v_w;
    logic [DEMUX_NCH-1:0]   load_c;
    logic [N-1:0]           y_w [DEMUX_NCH];
    logic                   ready_c;
    logic                   accept_c;

    assign r_c = {r3, r2, r1, r0};

    // Ready depends only on the chosen slot, never on d_valid.
    always_comb begin
        dst_c    = auto ? demux_sel_e'(rr_ptr_q) : demux_sel_e'(s);
        ready_c  = ~v_w[dst_c] | r_c[dst_c];
        accept_c = d_valid & ready_c;
        load_c   = '0;
        if (accept_c) begin
            case (dst_c)
                CH0:     load_c[0] = 1'b1;
                CH1:     load_c[1] = 1'b1;
                CH2:     load_c[2] = 1'b1;
                CH3:     load_c[3] = 1'b1;
                default: load_c    = '0;
            endcase
        end
        rr_ptr_d = rr_ptr_q;
        if (accept_c && auto) begin
            rr_ptr_d = rr_next(rr_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar k = 0; k < DEMUX_NCH; k++) begin : g_slot
        demux_slot #(.N(N)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load_c[k]),
            .load_data (d),
            .rdy       (r_c[k]),
            .y         (y_w[k]),
            .v         (v_w[k])
        );
    end

    assign d_ready = ready_c;
    assign rr_ptr  = rr_ptr_q;
    assign y0 = y_w[0];
    assign y1 = y_w[1];
    assign y2 = y_w[2];
    assign y3 = y_w[3];
    assign v0 = v_w[0];
    assign v1 = v_w[1];
    assign v2 = v_w[2];
    assign v3 = v_w[3];

endmodule
